// File: rtl/mux_stream_demux.sv
// Purpose: steers a packet stream onto one of four output channels; in_sel picks the channel on the first beat, and the channel stays locked until the last beat.
// Latency: one cycle. A beat accepted at edge k is valid on its channel's output register from edge k.
// Backpressure: in_ready follows only the target channel (empty or draining this cycle); the other channels drain independently.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   in_data/in_sel/in_valid/in_last/in_ready   input stream (in_sel used on a packet's first beat only)
//   out_data/out_valid/out_last/out_ready      four output channels, channel i data at [i*DATA_W +: DATA_W]
//   busy, cur_port                lock status and currently (or last) locked channel
module mux_stream_demux #(
    parameter int DATA_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DATA_W-1:0]   in_data,
    input  logic [1:0]          in_sel,
    input  logic                in_valid,
    input  logic                in_last,
    output logic                in_ready,
    output logic [4*DATA_W-1:0] out_data,
    output logic [3:0]          out_valid,
    output logic [3:0]          out_last,
    input  logic [3:0]          out_ready,
    output logic                busy,
    output logic [1:0]          cur_port
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  target;
    logic        accept;

    // Output-side registers: one entry per channel.
    logic [DATA_W-1:0] data_q [4];
    logic [3:0]        valid_q;
    logic [3:0]        last_q;

    // A channel can take a beat when empty or when its current beat leaves this cycle.
    assign in_ready = !valid_q[target] || out_ready[target];
    assign accept   = in_valid && in_ready;

    // State register; cur_port is captured only on a packet's first beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cur_port <= 2'd0;
        end else begin
            state <= state_nxt;
            if (accept && state == IDLE) begin
                cur_port <= in_sel;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept && !in_last) begin
                    state_nxt = LOCKED;
                end
            end
            LOCKED: begin
                if (accept && in_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: in_sel is ignored once a packet holds the lock.
    always_comb begin
        busy   = 1'b0;
        target = in_sel;
        if (state == LOCKED) begin
            busy   = 1'b1;
            target = cur_port;
        end
    end

    // Channel registers. A load wins over a drain so a same-cycle drain+load keeps
    // valid high; a drain alone clears valid but leaves data/last as they were.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 4'b0000;
            last_q  <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (accept && target == 2'(i)) begin
                    valid_q[i] <= 1'b1;
                    last_q[i]  <= in_last;
                    data_q[i]  <= in_data;
                end else if (out_ready[i]) begin
                    valid_q[i] <= 1'b0;
                end
            end
        end
    end

    assign out_valid = valid_q;
    assign out_last  = last_q;

    for (genvar g = 0; g < 4; g++) begin : g_out
        assign out_data[g*DATA_W +: DATA_W] = data_q[g];
    end

endmodule

// File: doc/mux_stream_demux.md
MUX_STREAM_DEMUX -- requirements
Module: mux_stream_demux

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the data width of the input and of each output channel.
REQ-002 The block SHALL have four output channels, fixed by the 2-bit select.
REQ-003 Port: clk  input  1  single clock; all state changes on the rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: in_data  input  DATA_W  input beat payload.
REQ-006 Port: in_sel  input  2  destination channel; sampled only on a packet's first beat.
REQ-007 Port: in_valid  input  1  input beat present.
REQ-008 Port: in_last  input  1  current beat is the final beat of its packet.
REQ-009 Port: in_ready  output  1  block accepts the beat this cycle.
REQ-010 Port: out_data  output  4*DATA_W  channel i payload at bits [i*DATA_W +: DATA_W].
REQ-011 Port: out_valid  output  4  per-channel beat present.
REQ-012 Port: out_last  output  4  per-channel last flag.
REQ-013 Port: out_ready  input  4  per-channel sink ready.
REQ-014 Port: busy  output  1  high while a multi-beat packet is locked to a channel.
REQ-015 Port: cur_port  output  2  channel currently locked (or last locked).

Function
REQ-016 Input handshake: beat accepted on a rising edge where in_valid && in_ready; output handshake per channel i: out_valid[i] && out_ready[i].
REQ-017 The FSM SHALL have two states, IDLE and LOCKED.
REQ-018 Target channel SHALL be in_sel in IDLE and cur_port in LOCKED; in_sel ignored in LOCKED.
REQ-019 IDLE, beat accepted: cur_port <= in_sel; next state LOCKED if in_last=0, stay IDLE if in_last=1 (single-beat packet).
REQ-020 LOCKED, beat accepted with in_last=1: next state IDLE; with in_last=0: stay LOCKED.
REQ-021 busy SHALL equal (state == LOCKED).
REQ-022 Each channel SHALL hold a one-entry output register (valid, data, last).
REQ-023 in_ready SHALL be !out_valid[t] || out_ready[t], t = target channel; independent of in_valid; combinational path out_ready -> in_ready is permitted.
REQ-024 Latency: beat accepted at edge k SHALL appear on out_data/out_last of the target channel with out_valid high from edge k (visible in cycle k+1).
REQ-025 Throughput: with target out_ready held high, one beat per cycle SHALL be sustained, including across packet boundaries.
REQ-026 Simultaneous drain and load on the same channel: register reloads with the new beat, out_valid stays 1.
REQ-027 Drain without load: out_valid[i] <= 0; out_data/out_last hold their previous value.
REQ-028 Non-target channels SHALL drain independently and concurrently; no beat SHALL be duplicated, dropped or reordered.
REQ-029 Packet switch: a new packet to a different channel SHALL be accepted while the previous channel still holds an undrained beat.

Reset
REQ-030 On rst high, asynchronously: state IDLE, cur_port 0, busy 0, out_valid 0, out_last 0, out_data 0.
REQ-031 Reset mid-packet SHALL discard all held beats and the lock; after release, the next beat is treated as a packet start.
REQ-032 in_ready SHALL be 1 while rst is high and in the first cycle after release, all out_valid being 0.

Verification
REQ-033 Single beat: in_sel=2, in_data=8'hA5, in_last=1, out_ready=4'hF -> next cycle out_valid=4'b0100, channel 2 data 8'hA5, out_last[2]=1, busy stays 0.
REQ-034 Lock: 3-beat packet 8'h11,8'h22,8'h33 with in_sel=1,3,0 per beat -> all three beats on channel 1 in order, last only on 8'h33; busy 1 from beat 1 until after beat 3.
REQ-035 Backpressure: channel 3 loaded, out_ready[3]=0, next beat to channel 3 -> in_ready=0 and the beat held; raise out_ready[3] -> accepted, no loss.
REQ-036 Switch under stall: channel 0 holds a beat with out_ready[0]=0, new single-beat packet in_sel=1 -> accepted immediately, out_valid=4'b0011.
REQ-037 Streaming: 16 back-to-back single-beat packets cycling sel 0..3, out_ready=4'hF -> in_ready constantly 1, each channel receives 4 beats in order.
REQ-038 Reset mid-packet: assert rst after beat 2 of a 4-beat packet -> out_valid=0, busy=0; next packet with in_sel=2 routes to channel 2.
